// File: rtl/analysis_sequencer.sv
// Measurement-window sequencer: arms on start, accumulates in-range RR intervals,
// hands the window to the final comparator and reports or faults on a ms timeout.
module analysis_sequencer #(
  parameter int N_BEATS    = 8,
  parameter int RR_MIN_MS  = 300,
  parameter int RR_MAX_MS  = 2000,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1ms,
  input  logic        start,
  input  logic        abort,
  input  logic        new_rr,
  input  logic [11:0] rr_interval_ms,
  input  logic        live_flag,
  input  logic        final_done,
  output logic        live_en,
  output logic        final_start,
  output logic [15:0] rr_sum,
  output logic [3:0]  beat_count,
  output logic [3:0]  irregular_count,
  output logic [3:0]  reject_count,
  output logic [2:0]  state,
  output logic        busy,
  output logic        result_valid,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    ANALYZE = 3'd3,
    REPORT  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [11:0] RR_MIN   = 12'(RR_MIN_MS);
  localparam logic [11:0] RR_MAX   = 12'(RR_MAX_MS);
  localparam logic [11:0] TO_LAST  = 12'(TIMEOUT_MS - 1);
  localparam logic [3:0]  LAST_BEAT = 4'(N_BEATS - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [11:0] ms_cnt;
  logic        clr_win;
  logic        accept;
  logic        reject;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        fstart;
  logic        in_range;

  assign in_range = (rr_interval_ms >= RR_MIN) && (rr_interval_ms <= RR_MAX);
  assign state    = cur_state;

  // The timeout tick only counts when no new_rr arrives in the same cycle.
  always_comb begin
    nxt_state = cur_state;
    clr_win   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    fstart    = 1'b0;
    if (abort) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE, REPORT, FAULT: begin
          if (start) begin
            nxt_state = ARM;
            clr_win   = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        ARM: begin
          if (new_rr) begin
            nxt_state = MEASURE;
            cnt_clr   = 1'b1;
          end else if (tick_1ms) begin
            cnt_inc = 1'b1;
            if (ms_cnt == TO_LAST) nxt_state = FAULT;
          end
        end
        MEASURE: begin
          if (new_rr) begin
            cnt_clr = 1'b1;
            if (in_range) begin
              accept = 1'b1;
              if (beat_count == LAST_BEAT) begin
                nxt_state = ANALYZE;
                fstart    = 1'b1;
              end
            end else begin
              reject = 1'b1;
            end
          end else if (tick_1ms) begin
            cnt_inc = 1'b1;
            if (ms_cnt == TO_LAST) nxt_state = FAULT;
          end
        end
        ANALYZE: begin
          if (final_done) begin
            nxt_state = REPORT;
          end else if (tick_1ms) begin
            cnt_inc = 1'b1;
            if (ms_cnt == TO_LAST) nxt_state = FAULT;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state       <= IDLE;
      ms_cnt          <= '0;
      rr_sum          <= '0;
      beat_count      <= '0;
      irregular_count <= '0;
      reject_count    <= '0;
      live_en         <= 1'b0;
      final_start     <= 1'b0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      final_start  <= fstart;
      live_en      <= (nxt_state == MEASURE);
      busy         <= (nxt_state == ARM) || (nxt_state == MEASURE) || (nxt_state == ANALYZE);
      result_valid <= (nxt_state == REPORT);
      timeout_err  <= (nxt_state == FAULT);

      if (cnt_clr)      ms_cnt <= '0;
      else if (cnt_inc) ms_cnt <= ms_cnt + 12'd1;

      if (clr_win) begin
        rr_sum          <= '0;
        beat_count      <= '0;
        irregular_count <= '0;
        reject_count    <= '0;
      end else if (accept) begin
        rr_sum     <= rr_sum + {4'd0, rr_interval_ms};
        beat_count <= beat_count + 4'd1;
        if (live_flag) irregular_count <= irregular_count + 4'd1;
      end else if (reject && reject_count != 4'hF) begin
        reject_count <= reject_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_analysis_sequencer.sv
// Directed self-checking bench for analysis_sequencer with default parameters.
module tb_analysis_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1ms = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        new_rr = 1'b0;
  logic [11:0] rr_interval_ms = '0;
  logic        live_flag = 1'b0;
  logic        final_done = 1'b0;
  logic        live_en;
  logic        final_start;
  logic [15:0] rr_sum;
  logic [3:0]  beat_count;
  logic [3:0]  irregular_count;
  logic [3:0]  reject_count;
  logic [2:0]  state;
  logic        busy;
  logic        result_valid;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  analysis_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms), .start(start), .abort(abort),
    .new_rr(new_rr), .rr_interval_ms(rr_interval_ms), .live_flag(live_flag),
    .final_done(final_done), .live_en(live_en), .final_start(final_start),
    .rr_sum(rr_sum), .beat_count(beat_count), .irregular_count(irregular_count),
    .reject_count(reject_count), .state(state), .busy(busy),
    .result_valid(result_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic pulse_done();
    final_done = 1'b1; step(); final_done = 1'b0;
  endtask

  task automatic send_rr(input logic [11:0] v, input logic flag);
    new_rr = 1'b1; rr_interval_ms = v; live_flag = flag;
    step();
    new_rr = 1'b0; live_flag = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1; step(); tick_1ms = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    tests++; if (state !== 3'd0) begin fails++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    tests++; if ({live_en, final_start, busy, result_valid, timeout_err} !== 5'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", {live_en, final_start, busy, result_valid, timeout_err}); end
    tests++; if ({rr_sum, beat_count, irregular_count, reject_count} !== 28'd0) begin fails++; $display("[TB] FAIL reset_counts: got %h expected 0", {rr_sum, beat_count, irregular_count, reject_count}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    pulse_start();
    tests++; if (state !== 3'd1 || busy !== 1'b1) begin fails++; $display("[TB] FAIL nom_arm: got state %0d busy %b expected 1 1", state, busy); end
    send_rr(12'd800, 1'b0);
    tests++; if (state !== 3'd2 || beat_count !== 4'd0 || live_en !== 1'b1) begin fails++; $display("[TB] FAIL nom_discard: got state %0d beats %0d live_en %b expected 2 0 1", state, beat_count, live_en); end
    for (int i = 0; i < 8; i++) send_rr(12'd800, 1'b0);
    tests++; if (state !== 3'd3 || final_start !== 1'b1 || live_en !== 1'b0) begin fails++; $display("[TB] FAIL nom_analyze: got state %0d final_start %b live_en %b expected 3 1 0", state, final_start, live_en); end
    tests++; if (rr_sum !== 16'd6400 || beat_count !== 4'd8) begin fails++; $display("[TB] FAIL nom_sum: got sum %0d beats %0d expected 6400 8", rr_sum, beat_count); end
    step();
    tests++; if (final_start !== 1'b0 || state !== 3'd3) begin fails++; $display("[TB] FAIL nom_pulse_width: got final_start %b state %0d expected 0 3", final_start, state); end
    pulse_done();
    tests++; if (state !== 3'd4 || result_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL nom_report: got state %0d valid %b busy %b expected 4 1 0", state, result_valid, busy); end
    step();
    tests++; if (rr_sum !== 16'd6400 || result_valid !== 1'b1) begin fails++; $display("[TB] FAIL nom_hold: got sum %0d valid %b expected 6400 1", rr_sum, result_valid); end
  endtask

  task automatic test_reject();
    logic [11:0] seq [10] = '{12'd1000, 12'd250, 12'd1000, 12'd1000, 12'd1000, 12'd2100, 12'd1000, 12'd1000, 12'd1000, 12'd1000};
    pulse_start();
    tests++; if (state !== 3'd1 || rr_sum !== 16'd0 || beat_count !== 4'd0) begin fails++; $display("[TB] FAIL rej_restart: got state %0d sum %0d beats %0d expected 1 0 0", state, rr_sum, beat_count); end
    send_rr(12'd700, 1'b0);
    for (int i = 0; i < 10; i++) send_rr(seq[i], 1'b0);
    tests++; if (reject_count !== 4'd2 || rr_sum !== 16'd8000 || beat_count !== 4'd8) begin fails++; $display("[TB] FAIL rej_window: got rej %0d sum %0d beats %0d expected 2 8000 8", reject_count, rr_sum, beat_count); end
    tests++; if (state !== 3'd3) begin fails++; $display("[TB] FAIL rej_state: got %0d expected 3", state); end
    pulse_abort();
  endtask

  task automatic test_boundary();
    pulse_start();
    send_rr(12'd100, 1'b1);
    send_rr(12'd299, 1'b1);
    send_rr(12'd300, 1'b1);
    send_rr(12'd2000, 1'b0);
    send_rr(12'd2001, 1'b1);
    tests++; if (rr_sum !== 16'd2300 || beat_count !== 4'd2 || reject_count !== 4'd2 || irregular_count !== 4'd1) begin fails++; $display("[TB] FAIL bnd_limits: got sum %0d beats %0d rej %0d irr %0d expected 2300 2 2 1", rr_sum, beat_count, reject_count, irregular_count); end
    for (int i = 0; i < 16; i++) send_rr(12'd100, 1'b0);
    tests++; if (reject_count !== 4'd15 || rr_sum !== 16'd2300 || state !== 3'd2) begin fails++; $display("[TB] FAIL bnd_saturate: got rej %0d sum %0d state %0d expected 15 2300 2", reject_count, rr_sum, state); end
    pulse_abort();
    tests++; if (state !== 3'd0 || live_en !== 1'b0) begin fails++; $display("[TB] FAIL bnd_abort: got state %0d live_en %b expected 0 0", state, live_en); end
  endtask

  task automatic test_timeout();
    pulse_start();
    send_rr(12'd800, 1'b0);
    send_rr(12'd1000, 1'b1);
    send_rr(12'd100, 1'b0);
    do_ticks(2999);
    tests++; if (state !== 3'd2 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL to_early: got state %0d err %b expected 2 0", state, timeout_err); end
    do_ticks(1);
    tests++; if (state !== 3'd5 || timeout_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL to_fault: got state %0d err %b busy %b expected 5 1 0", state, timeout_err, busy); end
    pulse_start();
    tests++; if (state !== 3'd1 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL to_restart: got state %0d err %b expected 1 0", state, timeout_err); end
    tests++; if ({rr_sum, beat_count, irregular_count, reject_count} !== 28'd0) begin fails++; $display("[TB] FAIL to_clear: got %h expected 0", {rr_sum, beat_count, irregular_count, reject_count}); end
  endtask

  task automatic test_coincide();
    send_rr(12'd800, 1'b0);
    do_ticks(2999);
    tick_1ms = 1'b1;
    send_rr(12'd900, 1'b0);
    tick_1ms = 1'b0;
    tests++; if (state !== 3'd2 || beat_count !== 4'd1 || rr_sum !== 16'd900) begin fails++; $display("[TB] FAIL co_newrr_wins: got state %0d beats %0d sum %0d expected 2 1 900", state, beat_count, rr_sum); end
    do_ticks(2999);
    tests++; if (state !== 3'd2) begin fails++; $display("[TB] FAIL co_restart: got state %0d expected 2", state); end
    do_ticks(1);
    tests++; if (state !== 3'd5) begin fails++; $display("[TB] FAIL co_fault: got state %0d expected 5", state); end
  endtask

  task automatic test_abort();
    pulse_start();
    send_rr(12'd800, 1'b0);
    for (int i = 0; i < 8; i++) send_rr(12'd1000, 1'b0);
    step();
    pulse_start();
    tests++; if (state !== 3'd3 || rr_sum !== 16'd8000 || busy !== 1'b1) begin fails++; $display("[TB] FAIL ab_start_ignored: got state %0d sum %0d busy %b expected 3 8000 1", state, rr_sum, busy); end
    pulse_abort();
    tests++; if (state !== 3'd0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL ab_idle: got state %0d busy %b expected 0 0", state, busy); end
    pulse_done();
    tests++; if (state !== 3'd0 || result_valid !== 1'b0) begin fails++; $display("[TB] FAIL ab_done_ignored: got state %0d valid %b expected 0 0", state, result_valid); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulse_start();
    send_rr(12'd800, 1'b0);
    for (int i = 0; i < 5; i++) send_rr(12'd800, 1'b1);
    tests++; if (beat_count !== 4'd5 || irregular_count !== 4'd5 || rr_sum !== 16'd4000) begin fails++; $display("[TB] FAIL rm_window: got beats %0d irr %0d sum %0d expected 5 5 4000", beat_count, irregular_count, rr_sum); end
    rst_n = 1'b0;
    step();
    tests++; if (state !== 3'd0 || {rr_sum, beat_count, irregular_count, reject_count} !== 28'd0) begin fails++; $display("[TB] FAIL rm_cleared: got state %0d data %h expected 0 0", state, {rr_sum, beat_count, irregular_count, reject_count}); end
    tests++; if ({live_en, final_start, busy, result_valid, timeout_err} !== 5'b0) begin fails++; $display("[TB] FAIL rm_flags: got %b expected 00000", {live_en, final_start, busy, result_valid, timeout_err}); end
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send_rr(12'd800, 1'b0);
      if (final_start === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0 || state !== 3'd0) begin fails++; $display("[TB] FAIL rm_no_pulse: got pulses %0d state %0d expected 0 0", pulses, state); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reject();
    test_boundary();
    test_timeout();
    test_coincide();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
